mem_store_buffer: RTL and testbench

Word-granular store buffer between the EX/MEM pipeline register and the data memory of the pipelined MIPS core. Stores from the pipeline are queued in a small FIFO and retired to the data memory in cycles where its single port is otherwise free. Loads are serviced from the youngest matching buffered store when one exists, otherwise from memory. A drain request empties the buffer before ordering-sensitive operations, stalling the pipeline while it does so.

---
 rtl/mem_store_buffer.sv | 120 ++++++++++++
 tb/tb_mem_store_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: word-granular store buffer between EX/MEM and the data memory.
// Stores queue in a circular FIFO and retire to memory whenever the single memory
// port is otherwise free. Loads forward from the youngest matching entry. A drain
// request stalls the pipeline until every buffered store has been written out.
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     drainReq,
  output logic [DATA_W-1:0]        loadData,
  output logic                     stall,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ADDR_W-1:0]        dmAddr,
  output logic [DATA_W-1:0]        dmWriteData,
  output logic                     dmMemWrite,
  output logic                     dmMemRead,
  input  logic [DATA_W-1:0]        dmReadData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic [PTR_W-1:0]  w_hit_idx;
  logic [PTR_W-1:0]  w_idx;
  logic              w_drain;
  logic              w_st;
  logic              w_ld;
  logic              w_st_hit;
  logic              w_enq;
  logic              w_ld_hit;
  logic              w_ld_miss;
  logic              w_idle;
  logic              w_retire;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Address match across occupied entries, walked oldest to youngest so the youngest hit wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = w_idx;
      end
    end
  end

  // A pending drain owns the memory port and suppresses the pipeline op entirely.
  assign w_drain   = drainReq & ~w_empty;
  assign w_st      = memWrite & ~w_drain;
  assign w_ld      = memRead & ~w_drain;
  assign w_st_hit  = w_st & w_hit;
  assign w_enq     = w_st & ~w_hit;
  assign w_ld_hit  = w_ld & w_hit;
  assign w_ld_miss = w_ld & ~w_hit;
  assign w_idle    = ~memWrite & ~memRead;

  // Full-miss store retires head and enqueues at tail together; when full those are
  // the same slot, which is safe because the retire reads the old contents this cycle.
  assign w_retire = w_drain | (w_enq & w_full) | ((w_ld_hit | w_idle) & ~w_empty);

  assign stall       = w_drain;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign dmMemWrite  = w_retire & ~reset;
  assign dmMemRead   = w_ld_miss;
  assign dmAddr      = w_retire ? r_addr[r_head] : addr;
  assign dmWriteData = r_data[r_head];
  assign loadData    = w_ld_hit ? r_data[w_hit_idx] : dmReadData;

  // FIFO state: coalesce store hits in place, enqueue misses, advance head on retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_st_hit) begin
        r_data[w_hit_idx] <= writeData;
      end
      if (w_enq) begin
        r_addr[r_tail] <= addr;
        r_data[r_tail] <= writeData;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_retire);
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed testbench for mem_store_buffer with a small data-memory model.
module tb_mem_store_buffer;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        drainReq;
  logic [31:0] loadData;
  logic        stall;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic [31:0] dmAddr;
  logic [31:0] dmWriteData;
  logic        dmMemWrite;
  logic        dmMemRead;
  logic [31:0] dmReadData;

  int total = 0;
  int bad   = 0;

  // Memory model: unwritten words read back as F000_00xx so forwarding is distinguishable.
  bit [31:0] mem [256];
  bit        mem_wr [256];
  int        wr_cnt = 0;

  assign dmReadData = mem_wr[dmAddr[7:0]] ? mem[dmAddr[7:0]] : (32'hF000_0000 | {24'h0, dmAddr[7:0]});

  always @(posedge clk) begin
    if (dmMemWrite) begin
      mem[dmAddr[7:0]]    <= dmWriteData;
      mem_wr[dmAddr[7:0]] <= 1'b1;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .writeData(writeData), .drainReq(drainReq),
    .loadData(loadData), .stall(stall), .full(full), .empty(empty), .count(count),
    .dmAddr(dmAddr), .dmWriteData(dmWriteData), .dmMemWrite(dmMemWrite),
    .dmMemRead(dmMemRead), .dmReadData(dmReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic dr);
    memRead = rd; memWrite = wr; addr = a; writeData = d; drainReq = dr;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 32'd3, 32'd0, 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 32'd3, 32'd0, 0);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({stall, empty, full} !== 3'b010) begin bad++; $display("FAIL reset_flags got=%b exp=010", {stall, empty, full}); end
    total++; if ({dmMemWrite, dmMemRead} !== 2'b00) begin bad++; $display("FAIL reset_dm got=%b exp=00", {dmMemWrite, dmMemRead}); end
    total++; if (loadData !== 32'hF000_0003) begin bad++; $display("FAIL reset_loaddata got=%h exp=f0000003", loadData); end
  endtask

  task automatic test_store_idle();
    drive(0, 1, 32'd4, 32'd10, 0);
    total++; if (dmMemWrite !== 1'b0) begin bad++; $display("FAIL st_nowrite got=%b exp=0", dmMemWrite); end
    tick();
    drive(0, 0, 32'd0, 32'd0, 0);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL st_count got=%0d exp=1", count); end
    total++; if ({dmMemWrite, dmAddr, dmWriteData} !== {1'b1, 32'd4, 32'd10})
      begin bad++; $display("FAIL idle_retire got=%b/%0d/%0d exp=1/4/10", dmMemWrite, dmAddr, dmWriteData); end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL idle_empty got=%b exp=1", empty); end
    total++; if (mem[4] !== 32'd10) begin bad++; $display("FAIL idle_mem got=%0d exp=10", mem[4]); end
  endtask

  task automatic test_load_hit();
    drive(0, 1, 32'd6, 32'd10, 0);
    tick();
    drive(1, 0, 32'd6, 32'd0, 0);
    total++; if (loadData !== 32'd10) begin bad++; $display("FAIL ldhit_data got=%h exp=a", loadData); end
    total++; if (dmMemRead !== 1'b0) begin bad++; $display("FAIL ldhit_rd got=%b exp=0", dmMemRead); end
    total++; if ({dmMemWrite, dmAddr, dmWriteData} !== {1'b1, 32'd6, 32'd10})
      begin bad++; $display("FAIL ldhit_retire got=%b/%0d/%0d exp=1/6/10", dmMemWrite, dmAddr, dmWriteData); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL ldhit_cnt1 got=%0d exp=1", count); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL ldhit_cnt0 got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 32'(i), 32'(10 + i), 0);
      total++; if (dmMemWrite !== 1'b0) begin bad++; $display("FAIL b2b_nowrite%0d got=%b exp=0", i, dmMemWrite); end
      tick();
    end
    drive(0, 1, 32'd5, 32'd15, 0);
    total++; if ({full, count} !== {1'b1, 3'd4}) begin bad++; $display("FAIL b2b_full got=%b/%0d exp=1/4", full, count); end
    total++; if ({stall, dmMemWrite, dmAddr, dmWriteData} !== {1'b0, 1'b1, 32'd1, 32'd11})
      begin bad++; $display("FAIL b2b_fullmiss got=%b/%b/%0d/%0d exp=0/1/1/11", stall, dmMemWrite, dmAddr, dmWriteData); end
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL b2b_cnt got=%0d exp=4", count); end
    for (int i = 2; i <= 5; i++) begin
      drive(0, 0, 32'd0, 32'd0, 0);
      total++; if ({dmMemWrite, dmAddr, dmWriteData} !== {1'b1, 32'(i), 32'(10 + i)})
        begin bad++; $display("FAIL b2b_order%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, dmMemWrite, dmAddr, dmWriteData, i, 10 + i); end
      tick();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_coalesce();
    int w0;
    w0 = wr_cnt;
    drive(0, 1, 32'd7, 32'hA, 0); tick();
    drive(0, 1, 32'd7, 32'hB, 0);
    total++; if (dmMemWrite !== 1'b0) begin bad++; $display("FAIL coal_nowrite got=%b exp=0", dmMemWrite); end
    tick();
    drive(1, 0, 32'd7, 32'd0, 0);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL coal_cnt got=%0d exp=1", count); end
    total++; if (loadData !== 32'hB) begin bad++; $display("FAIL coal_data got=%h exp=b", loadData); end
    tick();
    drive(0, 0, 32'd0, 32'd0, 0);
    total++; if (dmMemWrite !== 1'b0) begin bad++; $display("FAIL coal_idle got=%b exp=0", dmMemWrite); end
    tick();
    total++; if (mem[7] !== 32'hB) begin bad++; $display("FAIL coal_mem got=%h exp=b", mem[7]); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL coal_writes got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_drain();
    int cyc;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 32'(i), 32'(20 + i), 0); tick();
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 32'd2, 32'd0, 1);
      total++; if ({stall, dmMemWrite, dmMemRead, dmAddr, dmWriteData} !== {1'b1, 1'b1, 1'b0, 32'(i), 32'(20 + i)})
        begin bad++; $display("FAIL drain%0d got=%b/%b/%b/%0d/%0d exp=1/1/0/%0d/%0d", i, stall, dmMemWrite, dmMemRead, dmAddr, dmWriteData, i, 20 + i); end
      tick();
    end
    // Waiting for the stall to clear is bounded; the drain must finish in DEPTH cycles.
    cyc = 0;
    drive(1, 0, 32'd9, 32'd0, 1);
    while (stall === 1'b1 && cyc < 8) begin tick(); drive(1, 0, 32'd9, 32'd0, 1); cyc++; end
    total++; if (cyc !== 0) begin bad++; $display("FAIL drain_len got=%0d extra stall cycles exp=0", cyc); end
    total++; if ({stall, dmMemRead, dmMemWrite, dmAddr} !== {1'b0, 1'b1, 1'b0, 32'd9})
      begin bad++; $display("FAIL drain_load got=%b/%b/%b/%0d exp=0/1/0/9", stall, dmMemRead, dmMemWrite, dmAddr); end
    total++; if (loadData !== 32'hF000_0009) begin bad++; $display("FAIL drain_ldata got=%h exp=f0000009", loadData); end
    tick();
  endtask

  task automatic test_reset_mid();
    int w0;
    drive(0, 1, 32'd10, 32'd30, 0); tick();
    drive(0, 1, 32'd11, 32'd31, 0); tick();
    w0 = wr_cnt;
    reset = 1'b1;
    drive(0, 0, 32'd0, 32'd0, 0);
    total++; if (dmMemWrite !== 1'b0) begin bad++; $display("FAIL rst_mid_write got=%b exp=0", dmMemWrite); end
    tick();
    reset = 1'b0;
    drive(0, 0, 32'd0, 32'd0, 0);
    total++; if ({count, empty, dmMemWrite} !== {3'd0, 1'b1, 1'b0})
      begin bad++; $display("FAIL rst_mid_state got=%0d/%b/%b exp=0/1/0", count, empty, dmMemWrite); end
    tick(); tick();
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL rst_mid_writes got=%0d exp=0", wr_cnt - w0); end
  endtask

  initial begin
    reset = 1'b1;
    memRead = 0; memWrite = 0; addr = 0; writeData = 0; drainReq = 0;
    tick();
    test_reset();
    test_store_idle();
    test_load_hit();
    test_back_to_back();
    test_coalesce();
    test_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
